// File: rtl/spi_reg_target_pkg.sv
// Shared definitions for the SPI register target: FSM encoding, command byte
// layout and the SPI mode-0 idle levels of the pins.
package spi_reg_target_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_DATA = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int         CMD_W       = 8;
    localparam int         CMD_RW_BIT  = 7;
    localparam int         CMD_IDX_W   = 7;
    localparam logic [6:0] CLR_ERR_IDX = 7'h7F;

    // Mode 0: sck idles low, csb idles high, data sampled on the sck rise.
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CSB_IDLE  = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;
    localparam logic MISO_IDLE = 1'b0;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall pulses
// derived from the synchronized level.
module spi_pin_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_reg_target.sv
// SPI mode-0 target exposing NUM_REGS registers of REG_W bits, with a core
// writeback port that wins over SPI commits to the same register.
module spi_reg_target
    import spi_reg_target_pkg::*;
#(
    parameter int NUM_REGS    = 4,
    parameter int REG_W       = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sck,
    input  logic                      csb,
    input  logic                      mosi,
    output logic                      miso,
    input  logic [NUM_REGS-1:0]       wb_en,
    input  logic [NUM_REGS*REG_W-1:0] wb_val,
    output logic [NUM_REGS*REG_W-1:0] regs,
    output logic                      wr_strobe,
    output logic [6:0]                wr_idx,
    output logic                      err,
    output state_t                    o_dbg_state
);

    localparam int                   CNT_W         = $clog2(REG_W) + 1;
    localparam logic [CNT_W-1:0]     CNT_CMD_LOAD  = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0]     CNT_DATA_LOAD = CNT_W'(REG_W - 1);
    localparam logic [CMD_IDX_W-1:0] NUM_REGS_IDX  = CMD_IDX_W'(NUM_REGS);
    localparam logic [1:0]           WARM_DONE     = 2'(SYNC_STAGES);

    state_t                 r_state, w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CMD_W-1:0]       r_cmd;
    logic [REG_W-1:0]       r_shadow;
    logic [REG_W-1:0]       r_regs [NUM_REGS];
    logic                   r_miso;
    logic                   r_commit;
    logic [CMD_IDX_W-1:0]   r_commit_idx;
    logic                   r_wr_strobe;
    logic [CMD_IDX_W-1:0]   r_wr_idx;
    logic                   r_err;
    logic [1:0]             r_warm;
    logic                   r_armed;

    logic                   w_sck_sync, w_sck_rise, w_sck_fall;
    logic                   w_csb_sync, w_csb_rise, w_csb_fall;
    logic                   w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic [CMD_W-1:0]       w_cmd_byte;
    logic [CMD_IDX_W-1:0]   w_cmd_idx;
    logic                   w_cmd_rw, w_cmd_clr, w_cmd_valid, w_last_bit;
    logic [REG_W-1:0]       w_rd_snap;
    logic [NUM_REGS-1:0]    w_commit_hit;
    logic                   w_collide;
    logic                   w_unused_bits;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCK_IDLE)) u_sync_sck (
        .i_clk(clk), .i_rst_n(rst_n), .i_pin(sck),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CSB_IDLE)) u_sync_csb (
        .i_clk(clk), .i_rst_n(rst_n), .i_pin(csb),
        .o_sync(w_csb_sync), .o_rise(w_csb_rise), .o_fall(w_csb_fall)
    );
    spi_pin_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
        .i_clk(clk), .i_rst_n(rst_n), .i_pin(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused_bits = ^{w_sck_sync, w_mosi_rise, w_mosi_fall, r_cmd[CMD_W-1]};

    // A csb fall only opens a frame once csb has been seen high after reset,
    // so a frame interrupted by reset cannot be resumed mid-stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm  <= '0;
            r_armed <= 1'b0;
        end else begin
            if (r_warm != WARM_DONE) r_warm <= r_warm + 2'd1;
            if (r_warm == WARM_DONE && w_csb_sync) r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_cmd_byte  = {r_cmd[CMD_W-2:0], w_mosi_sync};
        w_cmd_rw    = w_cmd_byte[CMD_RW_BIT];
        w_cmd_idx   = w_cmd_byte[CMD_IDX_W-1:0];
        w_cmd_clr   = !w_cmd_rw && (w_cmd_idx == CLR_ERR_IDX);
        w_cmd_valid = w_cmd_idx < NUM_REGS_IDX;
        w_last_bit  = w_sck_rise && (r_cnt == '0);
        w_rd_snap   = '0;
        w_commit_hit = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_idx == CMD_IDX_W'(i)) w_rd_snap = r_regs[i];
            w_commit_hit[i] = r_commit && (r_commit_idx == CMD_IDX_W'(i));
        end
        w_collide = |(w_commit_hit & wb_en);
    end

    always_comb begin
        w_state_next = r_state;
        if (w_csb_rise) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_csb_fall && r_armed) w_state_next = ST_CMD;
                ST_CMD: begin
                    if (w_last_bit) begin
                        if (w_cmd_clr || !w_cmd_valid) w_state_next = ST_DONE;
                        else if (w_cmd_rw)             w_state_next = ST_RD_DATA;
                        else                           w_state_next = ST_WR_DATA;
                    end
                end
                ST_WR_DATA, ST_RD_DATA: if (w_last_bit) w_state_next = ST_DONE;
                default: w_state_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_cmd        <= '0;
            r_shadow     <= '0;
            r_miso       <= MISO_IDLE;
            r_commit     <= 1'b0;
            r_commit_idx <= '0;
            r_err        <= 1'b0;
        end else begin
            r_commit <= 1'b0;
            if (w_collide) r_err <= 1'b1;
            if (w_csb_rise) begin
                r_miso <= MISO_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_csb_fall && r_armed) begin
                            r_cnt <= CNT_CMD_LOAD;
                            r_cmd <= '0;
                        end
                    end
                    ST_CMD: begin
                        if (w_sck_rise) begin
                            r_cmd <= w_cmd_byte;
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end else if (w_cmd_clr) begin
                                r_err <= 1'b0;
                            end else if (!w_cmd_valid) begin
                                r_err <= 1'b1;
                            end else begin
                                r_cnt <= CNT_DATA_LOAD;
                                if (w_cmd_rw) r_shadow <= w_rd_snap;
                            end
                        end
                    end
                    ST_WR_DATA: begin
                        if (w_sck_rise) begin
                            r_shadow <= {r_shadow[REG_W-2:0], w_mosi_sync};
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - CNT_W'(1);
                            end else begin
                                r_commit     <= 1'b1;
                                r_commit_idx <= r_cmd[CMD_IDX_W-1:0];
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_sck_fall) begin
                            r_miso   <= r_shadow[REG_W-1];
                            r_shadow <= {r_shadow[REG_W-2:0], 1'b0};
                        end else if (w_sck_rise) begin
                            if (r_cnt != '0) r_cnt  <= r_cnt - CNT_W'(1);
                            else             r_miso <= MISO_IDLE;
                        end
                    end
                    default: r_miso <= MISO_IDLE;
                endcase
            end
        end
    end

    // Core writeback beats an SPI commit landing on the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wb_en[i])             r_regs[i] <= wb_val[i*REG_W +: REG_W];
                else if (w_commit_hit[i]) r_regs[i] <= r_shadow;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_strobe <= 1'b0;
            r_wr_idx    <= '0;
        end else begin
            r_wr_strobe <= r_commit;
            if (r_commit) r_wr_idx <= r_commit_idx;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign regs[g*REG_W +: REG_W] = r_regs[g];
    end

    assign miso        = r_miso;
    assign wr_strobe   = r_wr_strobe;
    assign wr_idx      = r_wr_idx;
    assign err         = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_spi_reg_target.sv
// Randomized frame-level bench for spi_reg_target with a register-file model
// and a queue of expected write-strobe indices.
module tb_spi_reg_target;
    import spi_reg_target_pkg::*;

    localparam int NUM_REGS = 4;
    localparam int REG_W    = 128;
    localparam int HALF     = 4;
    localparam int WB_REG   = 2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      sck = 1'b0;
    logic                      csb = 1'b1;
    logic                      mosi = 1'b0;
    logic                      miso;
    logic [NUM_REGS-1:0]       wb_en = '0;
    logic [NUM_REGS*REG_W-1:0] wb_val = '0;
    logic [NUM_REGS*REG_W-1:0] regs;
    logic                      wr_strobe;
    logic [6:0]                wr_idx;
    logic                      err;
    state_t                    dbg_state;

    logic [REG_W-1:0] model_regs [NUM_REGS];
    logic             model_err;
    logic [6:0]       exp_q [$];
    logic [6:0]       got_q [$];
    int               tests = 0;
    int               fails = 0;

    always #5 clk = ~clk;

    spi_reg_target #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sck(sck), .csb(csb), .mosi(mosi), .miso(miso),
        .wb_en(wb_en), .wb_val(wb_val), .regs(regs), .wr_strobe(wr_strobe),
        .wr_idx(wr_idx), .err(err), .o_dbg_state(dbg_state)
    );

    always @(negedge clk) if (rst_n && wr_strobe) got_q.push_back(wr_idx);

    task automatic check_eq(input string tag, input logic [REG_W-1:0] got, input logic [REG_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [REG_W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cs_low();
        csb = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        csb = 1'b1;
        repeat (4 * HALF) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic b, output logic m);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sck = 1'b1;
        m = miso;
        repeat (HALF) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [REG_W-1:0] data, input int nbits,
                         input int wb_bit, input logic collide, input logic [REG_W-1:0] wb_data,
                         output logic [REG_W-1:0] rdata);
        logic m;
        cs_low();
        for (int i = 7; i >= 0; i--) xfer_bit(cmd[i], m);
        rdata = '0;
        for (int i = 0; i < nbits; i++) begin
            if (collide && i == nbits - 1) begin
                wb_val[0 +: REG_W] = wb_data;
                wb_en[0] = 1'b1;
            end
            xfer_bit(data[REG_W-1-i], m);
            rdata[REG_W-1-i] = m;
            if (collide && i == nbits - 1) begin
                for (int k = 0; k < 12; k++) begin
                    if (wr_strobe) break;
                    @(negedge clk);
                end
                wb_en[0] = 1'b0;
            end
            if (i == wb_bit) begin
                wb_val[WB_REG*REG_W +: REG_W] = wb_data;
                wb_en[WB_REG] = 1'b1;
                @(negedge clk);
                wb_en[WB_REG] = 1'b0;
            end
        end
        cs_high();
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            check_eq($sformatf("%s_reg%0d", tag, i), regs[i*REG_W +: REG_W], model_regs[i]);
        check_eq({tag, "_err"}, REG_W'(err), REG_W'(model_err));
        check_eq({tag, "_state"}, REG_W'(dbg_state), REG_W'(ST_IDLE));
        check_eq({tag, "_strobe_n"}, REG_W'(got_q.size()), REG_W'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check_eq({tag, "_wr_idx"}, REG_W'(got_q.pop_front()), REG_W'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic do_frame(input string tag, input logic [7:0] cmd, input logic [REG_W-1:0] data,
                            input int nbits, input int wb_bit, input logic collide);
        logic             rw;
        logic [6:0]       idx;
        logic             in_range;
        logic [REG_W-1:0] exp_rd, wbd, rd;
        rw       = cmd[7];
        idx      = cmd[6:0];
        in_range = int'(idx) < NUM_REGS;
        wbd      = rand_word();
        exp_rd   = (rw && in_range) ? model_regs[idx] : '0;
        frame(cmd, data, nbits, wb_bit, collide, wbd, rd);
        if (!rw && idx == CLR_ERR_IDX) begin
            model_err = 1'b0;
        end else if (!in_range) begin
            model_err = 1'b1;
        end else if (!rw && nbits == REG_W) begin
            if (collide) begin
                model_regs[idx] = wbd;
                model_err = 1'b1;
            end else begin
                model_regs[idx] = data;
            end
            exp_q.push_back(idx);
        end
        if (wb_bit >= 0 && wb_bit < nbits) model_regs[WB_REG] = wbd;
        if (nbits == REG_W && (rw || !in_range)) check_eq({tag, "_miso"}, rd, exp_rd);
        check_all(tag);
    endtask

    initial begin
        logic       m;
        logic [7:0] cmd;
        int         kind, nbits, wb_bit;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        model_err = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_regs", REG_W'(regs != '0), '0);
        check_eq("rst_err", REG_W'(err), '0);
        check_eq("rst_miso", REG_W'(miso), '0);
        check_eq("rst_strobe", REG_W'(wr_strobe), '0);
        check_eq("rst_wr_idx", REG_W'(wr_idx), '0);
        check_eq("rst_state", REG_W'(dbg_state), REG_W'(ST_IDLE));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        do_frame("wr2", 8'h02, 128'h0123456789ABCDEF0123456789ABCDEF, REG_W, -1, 1'b0);
        do_frame("rd2_wb", 8'h82, '0, REG_W, 40, 1'b0);
        do_frame("wr1_abort", 8'h01, rand_word(), 60, -1, 1'b0);
        do_frame("oor5", 8'h05, rand_word(), REG_W, -1, 1'b0);
        do_frame("clr", 8'h7F, '0, 0, -1, 1'b0);
        do_frame("collide0", 8'h00, rand_word(), REG_W, -1, 1'b1);
        do_frame("clr2", 8'h7F, '0, 0, -1, 1'b0);

        // Reset in the middle of a write, then let the old frame run on.
        cs_low();
        for (int i = 7; i >= 0; i--) xfer_bit(cmd_bit(8'h03, i), m);
        for (int i = 0; i < 30; i++) xfer_bit(1'($urandom_range(0, 1)), m);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) model_regs[i] = '0;
        model_err = 1'b0;
        for (int i = 0; i < 98; i++) xfer_bit(1'($urandom_range(0, 1)), m);
        cs_high();
        check_all("rst_abort");
        do_frame("wr3_after_rst", 8'h03, rand_word(), REG_W, -1, 1'b0);

        for (int n = 0; n < 12; n++) begin
            kind   = $urandom_range(0, 9);
            nbits  = REG_W;
            wb_bit = -1;
            if (kind <= 3) begin
                cmd = {1'b0, 7'($urandom_range(0, NUM_REGS - 1))};
            end else if (kind <= 6) begin
                cmd = {1'b1, 7'($urandom_range(0, NUM_REGS - 1))};
                if ($urandom_range(0, 1) == 1) wb_bit = $urandom_range(0, REG_W - 2);
            end else if (kind == 7) begin
                cmd = {1'($urandom_range(0, 1)), 7'($urandom_range(NUM_REGS, 126))};
            end else if (kind == 8) begin
                cmd = 8'h7F;
                nbits = 0;
            end else begin
                cmd = {1'b0, 7'($urandom_range(0, NUM_REGS - 1))};
                nbits = $urandom_range(1, REG_W - 1);
            end
            do_frame($sformatf("rand%0d", n), cmd, rand_word(), nbits, wb_bit, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    function automatic logic cmd_bit(input logic [7:0] c, input int i);
        return c[i];
    endfunction

endmodule
